updown_counter_n: RTL and testbench

- Parametrised synchronous up/down counter with parallel load, terminal-count and ripple-carry outputs, and a selectable modulus.
- Successor to the 4-bit TTL counter model; supports arbitrary width, non-power-of-two modulus and saturating mode.
- Fully synchronous to one clock, with no clock-gated carry, so stages cascade cleanly through the enable chain.
- Used for playfield vertical/horizontal scroll and other video timing counters.

---
 rtl/updown_counter_n.sv | 129 ++++++++++++
 tb/tb_updown_counter_n.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_n.sv
// ---------------------------------------------------------------------------
// updown_counter_n
// Parametrised synchronous up/down counter with synchronous parallel load,
// selectable modulus, optional saturation, a combinational terminal count,
// an active-low ripple carry for enable-chain cascading, and a registered
// one-cycle wrap pulse. All state changes on the rising edge of clk; the only
// asynchronous path is the active-low reset.
// ---------------------------------------------------------------------------
module updown_counter_n #(
    parameter int WIDTH    = 4,            // counter width in bits, 1..16
    parameter int MODULUS  = 2 ** WIDTH,   // count range 0..MODULUS-1, 2..2**WIDTH
    parameter int SATURATE = 0             // 0: wrap at terminal value, 1: hold
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             ce_b,
    input  logic             du,
    input  logic             load_b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             rc_b,
    output logic             wrap_p
);

    // Highest legal count value. MODULUS never exceeds 2**WIDTH, so this
    // always fits in WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    // Modulus held one bit wider so that MODULUS == 2**WIDTH is representable
    // and the load clamp compare collapses to constant false in that case.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

    localparam bit SAT_EN = (SATURATE != 0);

    // Operation selected for the coming edge, in priority order.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_COUNT = 2'd2
    } op_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    op_e              op;
    logic             at_max;
    logic             at_zero;
    logic             d_over;
    logic [WIDTH-1:0] load_val;

    assign at_max  = (q_q == MAX_VAL);
    assign at_zero = (q_q == '0);

    // Load data outside the count range is clamped to the top value so that
    // q can never be observed at or above MODULUS.
    assign d_over   = ({1'b0, d} >= MOD_EXT);
    assign load_val = d_over ? MAX_VAL : d;

    // Decode the operation for this cycle: load beats count beats hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        op = OP_HOLD;
        if (!load_b) begin
            op = OP_LOAD;
        end else if (!ce_b) begin
            op = OP_COUNT;
        end
    end

    // Next-state logic for the count value and the wrap flag.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        unique case (op)
            OP_LOAD: begin
                q_d = load_val;
            end
            OP_COUNT: begin
                if (!du) begin
                    // Counting up: increment below the top, else wrap or hold.
                    if (!at_max) begin
                        q_d = q_q + WIDTH'(1);
                    end else if (!SAT_EN) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    // Counting down: decrement above zero, else wrap or hold.
                    if (!at_zero) begin
                        q_d = q_q - WIDTH'(1);
                    end else if (!SAT_EN) begin
                        q_d    = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end
            end
            default: begin
                q_d    = q_q;
                wrap_d = 1'b0;
            end
        endcase
    end

    // Count and wrap-pulse registers, cleared asynchronously by reset_b.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values of its inputs.
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q      = q_q;
    assign wrap_p = wrap_q;

    // Terminal count tracks du combinationally, so a direction change is
    // visible in the same cycle without waiting for an edge.
    assign tc = du ? at_zero : at_max;

    // Ripple carry has no clock term; the next stage uses it as its count
    // enable on the shared clock. A saturating counter never carries.
    assign rc_b = SAT_EN ? 1'b1 : ~(~ce_b & tc);

endmodule

// File: tb/tb_updown_counter_n.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_n
// Directed bench for updown_counter_n. Five instances share one clock and
// reset: a binary wrapping counter, a modulus-10 counter, a saturating 3-bit
// counter, and a two-stage cascade chained through rc_b -> ce_b.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_updown_counter_n;

    logic clk;
    logic reset_b;

    // Instance a: WIDTH=4, MODULUS=16, wrapping
    logic       a_ce_b, a_du, a_load_b;
    logic [3:0] a_d, a_q;
    logic       a_tc, a_rc_b, a_wrap;

    // Instance b: WIDTH=4, MODULUS=10, wrapping
    logic       b_ce_b, b_du, b_load_b;
    logic [3:0] b_d, b_q;
    logic       b_tc, b_rc_b, b_wrap;

    // Instance c: WIDTH=3, MODULUS=8, saturating
    logic       c_ce_b, c_du, c_load_b;
    logic [2:0] c_d, c_q;
    logic       c_tc, c_rc_b, c_wrap;

    // Cascade: lo drives hi's enable through its ripple carry
    logic       lo_ce_b, lo_du, lo_load_b;
    logic [3:0] lo_d, lo_q;
    logic       lo_tc, lo_rc_b, lo_wrap;
    logic       hi_du, hi_load_b;
    logic [3:0] hi_d, hi_q;
    logic       hi_tc, hi_rc_b, hi_wrap;

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    updown_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_a (
        .clk(clk), .reset_b(reset_b), .ce_b(a_ce_b), .du(a_du), .load_b(a_load_b),
        .d(a_d), .q(a_q), .tc(a_tc), .rc_b(a_rc_b), .wrap_p(a_wrap)
    );

    updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_b (
        .clk(clk), .reset_b(reset_b), .ce_b(b_ce_b), .du(b_du), .load_b(b_load_b),
        .d(b_d), .q(b_q), .tc(b_tc), .rc_b(b_rc_b), .wrap_p(b_wrap)
    );

    updown_counter_n #(.WIDTH(3), .MODULUS(8), .SATURATE(1)) u_c (
        .clk(clk), .reset_b(reset_b), .ce_b(c_ce_b), .du(c_du), .load_b(c_load_b),
        .d(c_d), .q(c_q), .tc(c_tc), .rc_b(c_rc_b), .wrap_p(c_wrap)
    );

    updown_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_lo (
        .clk(clk), .reset_b(reset_b), .ce_b(lo_ce_b), .du(lo_du), .load_b(lo_load_b),
        .d(lo_d), .q(lo_q), .tc(lo_tc), .rc_b(lo_rc_b), .wrap_p(lo_wrap)
    );

    updown_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_hi (
        .clk(clk), .reset_b(reset_b), .ce_b(lo_rc_b), .du(hi_du), .load_b(hi_load_b),
        .d(hi_d), .q(hi_q), .tc(hi_tc), .rc_b(hi_rc_b), .wrap_p(hi_wrap)
    );

    // One comparison: count it, and on mismatch count and report the failure.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam int B_DOWN_EXP [9] = '{6, 5, 4, 3, 2, 1, 0, 9, 8};

    initial begin
        total = 0;
        bad   = 0;
        reset_b = 1'b0;
        a_ce_b = 1'b1;  a_du = 1'b0;  a_load_b = 1'b1;  a_d = '0;
        b_ce_b = 1'b1;  b_du = 1'b0;  b_load_b = 1'b1;  b_d = '0;
        c_ce_b = 1'b1;  c_du = 1'b1;  c_load_b = 1'b1;  c_d = '0;
        lo_ce_b = 1'b1; lo_du = 1'b0; lo_load_b = 1'b1; lo_d = '0;
        hi_du = 1'b0;   hi_load_b = 1'b1; hi_d = '0;

        // ---- Reset state ----
        #3;
        check("rst_a_q", a_q, 0);
        check("rst_a_wrap", a_wrap, 0);
        check("rst_a_tc_up", a_tc, 0);
        check("rst_a_rc_b", a_rc_b, 1);
        check("rst_c_tc_down", c_tc, 1);
        check("rst_c_rc_b_sat", c_rc_b, 1);
        a_du = 1'b1; a_ce_b = 1'b0;
        #1;
        check("rst_a_tc_down", a_tc, 1);
        check("rst_a_rc_b_down_en", a_rc_b, 0);
        a_du = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_a_q_held", a_q, 0);
        reset_b = 1'b1;

        // ---- Binary wrap: 17 up counts from 0 ----
        for (int i = 1; i <= 17; i++) begin
            tick();
            check($sformatf("up16_q_%0d", i), a_q, i % 16);
            check($sformatf("up16_tc_%0d", i), a_tc, (i == 15) ? 1 : 0);
            check($sformatf("up16_rc_b_%0d", i), a_rc_b, (i == 15) ? 0 : 1);
            check($sformatf("up16_wrap_%0d", i), a_wrap, (i == 16) ? 1 : 0);
        end
        a_ce_b = 1'b1;
        tick();
        check("hold_a_q", a_q, 1);

        // ---- Modulus 10: load 7 then count down 9 ----
        b_load_b = 1'b0; b_d = 4'd7;
        tick();
        check("m10_load7_q", b_q, 7);
        b_load_b = 1'b1; b_du = 1'b1; b_ce_b = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("m10_down_q_%0d", i), b_q, B_DOWN_EXP[i]);
            check($sformatf("m10_down_tc_%0d", i), b_tc, (B_DOWN_EXP[i] == 0) ? 1 : 0);
            check($sformatf("m10_down_wrap_%0d", i), b_wrap, (i == 7) ? 1 : 0);
        end
        b_ce_b = 1'b1; b_load_b = 1'b0; b_d = 4'd12;
        tick();
        check("m10_clamp12_q", b_q, 9);
        b_d = 4'd5;
        tick();
        check("m10_load5_q", b_q, 5);
        b_d = 4'd10;
        tick();
        check("m10_clamp10_q", b_q, 9);
        b_load_b = 1'b1; b_du = 1'b0;
        #1;
        check("m10_tc_up_at9", b_tc, 1);
        check("m10_rc_b_disabled", b_rc_b, 1);

        // ---- Saturating 3-bit: count up 10 ----
        c_du = 1'b0; c_ce_b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("sat_q_%0d", i), c_q, (i >= 7) ? 7 : i);
            check($sformatf("sat_tc_%0d", i), c_tc, (i >= 7) ? 1 : 0);
            check($sformatf("sat_rc_b_%0d", i), c_rc_b, 1);
            check($sformatf("sat_wrap_%0d", i), c_wrap, 0);
        end
        c_du = 1'b1;
        #1;
        check("sat_tc_du_flip", c_tc, 0);
        tick();
        check("sat_down_q", c_q, 6);

        // ---- Cascade up from 0x0F ----
        lo_load_b = 1'b0; lo_d = 4'hF; hi_load_b = 1'b0; hi_d = 4'h0;
        tick();
        check("casc_load_0f", {hi_q, lo_q}, 8'h0F);
        lo_load_b = 1'b1; hi_load_b = 1'b1; lo_ce_b = 1'b0; lo_du = 1'b0; hi_du = 1'b0;
        #1;
        check("casc_lo_rc_b_up", lo_rc_b, 0);
        tick();
        check("casc_up_10", {hi_q, lo_q}, 8'h10);
        check("casc_lo_rc_b_idle", lo_rc_b, 1);
        tick();
        check("casc_up_11", {hi_q, lo_q}, 8'h11);

        // ---- Cascade down from 0x10 ----
        lo_load_b = 1'b0; lo_d = 4'h0; hi_load_b = 1'b0; hi_d = 4'h1;
        tick();
        check("casc_load_10", {hi_q, lo_q}, 8'h10);
        lo_load_b = 1'b1; hi_load_b = 1'b1; lo_du = 1'b1; hi_du = 1'b1;
        #1;
        check("casc_lo_rc_b_down", lo_rc_b, 0);
        tick();
        check("casc_down_0f", {hi_q, lo_q}, 8'h0F);
        tick();
        check("casc_down_0e", {hi_q, lo_q}, 8'h0E);

        // ---- Load wins over terminal count ----
        a_load_b = 1'b0; a_d = 4'd15;
        tick();
        check("ldtc_pre_q", a_q, 15);
        a_du = 1'b0; a_ce_b = 1'b0; a_d = 4'd3;
        tick();
        check("ldtc_q", a_q, 3);
        check("ldtc_wrap", a_wrap, 0);

        // ---- Wrap pulse cleared by a following load ----
        a_d = 4'd15;
        tick();
        a_load_b = 1'b1;
        tick();
        check("wrap_then_q", a_q, 0);
        check("wrap_then_pulse", a_wrap, 1);
        a_load_b = 1'b0; a_d = 4'd4;
        tick();
        check("wrap_cleared_by_load", a_wrap, 0);

        // ---- Reset mid-count ----
        a_load_b = 1'b1;
        tick();
        check("midrst_pre_q", a_q, 5);
        #2;
        reset_b = 1'b0;
        #1;
        check("midrst_q", a_q, 0);
        check("midrst_wrap", a_wrap, 0);
        @(negedge clk);
        reset_b = 1'b1;
        tick();
        check("midrst_first_count", a_q, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
